cc_cond_unit: RTL and testbench

Condition-code register and branch/move condition evaluator for the Y86-64 datapath. Captures the ZF/SF/OF flags produced by the ALU when an OPq instruction commits. Evaluates the jXX/cmovXX condition (`ifun`) against the held flags to produce `Cnd`. Also keeps a one-deep shadow snapshot of the flags so the control unit can roll back speculative flag updates.

---
 rtl/cc_cond_unit.sv | 103 ++++++++++
 tb/tb_cc_cond_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register with jXX/cmovXX condition evaluation and a
// one-deep shadow snapshot used to roll back speculative flag updates.
module cc_cond_unit #(
    parameter int unsigned FWD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_cc,
    input  logic       stall,
    input  logic       ZF_in,
    input  logic       SF_in,
    input  logic       OF_in,
    input  logic       snap,
    input  logic       restore,
    input  logic [3:0] ifun,
    output logic [2:0] CC,
    output logic       Cnd,
    output logic       cond_err,
    output logic       shadow_valid,
    output logic       restore_err
);

    localparam logic [2:0] CcReset = 3'b100;

    logic [2:0] cc_q, cc_d;
    logic [2:0] shadow_q, shadow_d;
    logic       sv_q, sv_d;
    logic       rerr_q, rerr_d;

    logic [2:0] flags_in;
    logic       restore_ok;
    logic       use_fwd;
    logic [2:0] f;
    logic       zf, x;

    assign flags_in   = {ZF_in, SF_in, OF_in};
    assign restore_ok = restore & sv_q;

    always_comb begin
        cc_d     = cc_q;
        shadow_d = shadow_q;
        sv_d     = sv_q;
        rerr_d   = 1'b0;
        if (!stall) begin
            if (restore_ok) begin
                cc_d = shadow_q;
                sv_d = 1'b0;
            end else begin
                if (set_cc) begin
                    cc_d = flags_in;
                end
                if (restore) begin
                    rerr_d = 1'b1;
                end
            end
            // Shadow always captures the pre-edge flags, so snap+restore swaps.
            if (snap) begin
                shadow_d = cc_q;
                sv_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q     <= CcReset;
            shadow_q <= CcReset;
            sv_q     <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            cc_q     <= cc_d;
            shadow_q <= shadow_d;
            sv_q     <= sv_d;
            rerr_q   <= rerr_d;
        end
    end

    // Forwarding only when the incoming flags are actually what CC will hold next.
    assign use_fwd = (FWD != 0) && set_cc && !stall && !restore_ok;
    assign f       = use_fwd ? flags_in : cc_q;
    assign zf      = f[2];
    assign x       = f[1] ^ f[0];

    always_comb begin
        Cnd      = 1'b0;
        cond_err = 1'b0;
        case (ifun)
            4'd0:    Cnd = 1'b1;
            4'd1:    Cnd = x | zf;
            4'd2:    Cnd = x;
            4'd3:    Cnd = zf;
            4'd4:    Cnd = ~zf;
            4'd5:    Cnd = ~x;
            4'd6:    Cnd = ~x & ~zf;
            default: cond_err = 1'b1;
        endcase
    end

    assign CC           = cc_q;
    assign shadow_valid = sv_q;
    assign restore_err  = rerr_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit: one instance per FWD setting, driven by the
// same stimulus, checked with immediate assertions against hand-computed values.
module tb_cc_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_cc;
    logic       stall;
    logic       ZF_in, SF_in, OF_in;
    logic       snap;
    logic       restore;
    logic [3:0] ifun;

    logic [2:0] u0_cc, u1_cc;
    logic       u0_cnd, u1_cnd;
    logic       u0_cerr, u1_cerr;
    logic       u0_sv, u1_sv;
    logic       u0_rerr, u1_rerr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cc_cond_unit #(.FWD(0)) u0 (
        .clk(clk), .rst(rst), .set_cc(set_cc), .stall(stall),
        .ZF_in(ZF_in), .SF_in(SF_in), .OF_in(OF_in),
        .snap(snap), .restore(restore), .ifun(ifun),
        .CC(u0_cc), .Cnd(u0_cnd), .cond_err(u0_cerr),
        .shadow_valid(u0_sv), .restore_err(u0_rerr)
    );

    cc_cond_unit #(.FWD(1)) u1 (
        .clk(clk), .rst(rst), .set_cc(set_cc), .stall(stall),
        .ZF_in(ZF_in), .SF_in(SF_in), .OF_in(OF_in),
        .snap(snap), .restore(restore), .ifun(ifun),
        .CC(u1_cc), .Cnd(u1_cnd), .cond_err(u1_cerr),
        .shadow_valid(u1_sv), .restore_err(u1_rerr)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sc, input logic sn, input logic rs, input logic st,
                         input logic [2:0] fl, input logic [3:0] fn);
        set_cc  = sc;
        snap    = sn;
        restore = rs;
        stall   = st;
        {ZF_in, SF_in, OF_in} = fl;
        ifun    = fn;
        #1;
    endtask

    // Step past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_cnd;
    logic [15:0] exp_err;

    initial begin
        exp_cnd = 16'h002B;
        exp_err = 16'hFF80;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_cc", 4'(u0_cc), 4'h4);
        chk("reset_sv", 4'(u0_sv), 4'h0);
        chk("reset_rerr", 4'(u0_rerr), 4'h0);
        chk("reset_cc_fwd", 4'(u1_cc), 4'h4);

        // Condition sweep on CC=100
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'(i));
            chk($sformatf("sweep_cnd_%0d", i), 4'(u0_cnd), 4'(exp_cnd[i]));
            chk($sformatf("sweep_err_%0d", i), 4'(u0_cerr), 4'(exp_err[i]));
        end

        // Negative flags, jl: forwarding visible only in the FWD=1 instance
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'd2);
        chk("l_setcc_nofwd", 4'(u0_cnd), 4'h0);
        chk("l_setcc_fwd", 4'(u1_cnd), 4'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd2);
        chk("l_next_nofwd", 4'(u0_cnd), 4'h1);
        chk("l_next_cc", 4'(u0_cc), 4'h2);

        // SF=OF=1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd5);
        chk("ge_011", 4'(u0_cnd), 4'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd6);
        chk("g_011", 4'(u0_cnd), 4'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1);
        chk("le_011", 4'(u0_cnd), 4'h0);

        // Snapshot / restore sequence
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0);
        tick();
        chk("load_001", 4'(u0_cc), 4'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 4'd0);
        tick();
        chk("snap_set_cc", 4'(u0_cc), 4'h4);
        chk("snap_set_sv", 4'(u0_sv), 4'h1);
        // Valid restore overrides set_cc and blocks forwarding
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 4'd3);
        chk("restore_no_fwd", 4'(u1_cnd), 4'h1);
        tick();
        chk("restore_cc", 4'(u0_cc), 4'h1);
        chk("restore_sv", 4'(u0_sv), 4'h0);
        chk("restore_rerr", 4'(u0_rerr), 4'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 4'd3);
        chk("restore_bad_fwd_cc", 4'(u1_cnd), 4'h0);
        tick();
        chk("restore2_cc", 4'(u0_cc), 4'h1);
        chk("restore2_rerr", 4'(u0_rerr), 4'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        tick();
        chk("rerr_pulse_end", 4'(u0_rerr), 4'h0);

        // Swap: shadow=010, CC=100
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 4'd0);
        tick();
        chk("pre_swap_cc", 4'(u0_cc), 4'h4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 4'd0);
        tick();
        chk("swap_cc", 4'(u0_cc), 4'h2);
        chk("swap_sv", 4'(u0_sv), 4'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0);
        tick();
        chk("swap_shadow", 4'(u0_cc), 4'h4);
        chk("swap_shadow_sv", 4'(u0_sv), 4'h0);

        // Stall: shadow=100 valid, CC=011
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0);
        tick();
        chk("pre_stall_cc", 4'(u0_cc), 4'h3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 4'd3);
            chk($sformatf("stall_fwd_cnd_%0d", i), 4'(u1_cnd), 4'h0);
            tick();
            chk($sformatf("stall_cc_%0d", i), 4'(u0_cc), 4'h3);
            chk($sformatf("stall_sv_%0d", i), 4'(u0_sv), 4'h1);
            chk($sformatf("stall_rerr_%0d", i), 4'(u0_rerr), 4'h0);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0);
        tick();
        chk("post_stall_restore", 4'(u0_cc), 4'h4);
        chk("post_stall_sv", 4'(u0_sv), 4'h0);

        // Stall forces restore_err low
        tick();
        chk("rerr_before_stall", 4'(u0_rerr), 4'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 4'd0);
        tick();
        chk("rerr_stall_clear", 4'(u0_rerr), 4'h0);

        // Reset overrides pending requests
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 4'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd3);
        chk("rst_cc", 4'(u0_cc), 4'h4);
        chk("rst_sv", 4'(u0_sv), 4'h0);
        chk("rst_rerr", 4'(u0_rerr), 4'h0);
        chk("rst_e", 4'(u0_cnd), 4'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd4);
        chk("rst_ne", 4'(u0_cnd), 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
